// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, icode classes and memory FSM states for the memory stage
package mem_stage_pkg;

    typedef logic [31:0] i32;
    typedef logic [5:0]  i6;
    typedef logic [4:0]  i5;
    typedef logic [3:0]  i4;
    typedef logic        i1;

    localparam i6 ICODE_NOP   = 6'd0;
    localparam i6 ICODE_SPE   = 6'd1;
    localparam i6 ICODE_ADDIU = 6'd2;
    localparam i6 ICODE_LW    = 6'd3;
    localparam i6 ICODE_SW    = 6'd4;
    localparam i6 ICODE_BEQ   = 6'd5;
    localparam i6 ICODE_LUI   = 6'd6;

    localparam i4 ACODE_ADD = 4'd0;
    localparam i4 ACODE_SUB = 4'd1;
    localparam i4 ACODE_AND = 4'd2;
    localparam i4 ACODE_OR  = 4'd3;

    localparam i32 DEFAULT_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input i6 icode);
        return (icode == ICODE_LW) || (icode == ICODE_SW);
    endfunction

endpackage

// File: rtl/mem_stage_dbus.sv
// rtl/mem_stage_dbus.sv - split-handshake data-bus controller: FSM, bus drive, read-data capture
module dbus_ctrl
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_write,
    input  logic [31:0] addr,
    input  logic [3:0]  strobe,
    input  logic [31:0] wdata,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        done,
    output logic [31:0] rdata
);

    mem_state_t  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MS_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Responses only matter in REQ/WAIT; IDLE and DONE just follow the pipeline advance.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            MS_IDLE, MS_DONE: state_d = start ? MS_REQ : MS_IDLE;
            MS_REQ: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        state_d = MS_DONE;
                        rdata_d = dresp_data;
                    end else begin
                        state_d = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                if (dresp_data_ok) begin
                    state_d = MS_DONE;
                    rdata_d = dresp_data;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        dreq_valid  = (state_q == MS_REQ);
        dreq_addr   = 32'h0;
        dreq_strobe = 4'h0;
        dreq_data   = 32'h0;
        if (dreq_valid) begin
            dreq_addr   = addr & ADDR_ALIGN_MASK;
            dreq_strobe = is_write ? strobe : 4'h0;
            dreq_data   = wdata;
        end
        done  = (state_q == MS_DONE);
        rdata = rdata_q;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: E/M pipeline register, data-bus access and writeback mux
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] M_pc,
    input  logic [31:0] M_val3,
    input  logic [31:0] M_valt,
    input  logic [5:0]  M_icode,
    input  logic [4:0]  M_dst,
    input  logic [3:0]  M_req,
    input  logic        M_bubble,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic [31:0] m_pc,
    output logic [5:0]  m_icode,
    output logic [4:0]  m_dst,
    output logic [31:0] m_val,
    output logic        m_wen,
    output logic        m_stall
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] val3_q, val3_d;
    logic [31:0] valt_q, valt_d;
    logic [5:0]  icode_q, icode_d;
    logic [4:0]  dst_q, dst_d;
    logic [3:0]  req_q, req_d;
    logic        bus_start;
    logic        bus_done;
    logic [31:0] bus_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= 32'h0;
            val3_q  <= 32'h0;
            valt_q  <= 32'h0;
            icode_q <= 6'h0;
            dst_q   <= 5'h0;
            req_q   <= 4'h0;
        end else begin
            pc_q    <= pc_d;
            val3_q  <= val3_d;
            valt_q  <= valt_d;
            icode_q <= icode_d;
            dst_q   <= dst_d;
            req_q   <= req_d;
        end
    end

    // A stalled stage holds everything, including over a pending bubble request.
    always_comb begin
        pc_d    = pc_q;
        val3_d  = val3_q;
        valt_d  = valt_q;
        icode_d = icode_q;
        dst_d   = dst_q;
        req_d   = req_q;
        if (!m_stall) begin
            if (M_bubble) begin
                pc_d    = 32'h0;
                val3_d  = 32'h0;
                valt_d  = 32'h0;
                icode_d = ICODE_NOP;
                dst_d   = 5'h0;
                req_d   = 4'h0;
            end else begin
                pc_d    = M_pc;
                val3_d  = M_val3;
                valt_d  = M_valt;
                icode_d = M_icode;
                dst_d   = M_dst;
                req_d   = M_req;
            end
        end
    end

    assign bus_start = !m_stall && !M_bubble && is_mem_op(M_icode);

    dbus_ctrl #(
        .ADDR_ALIGN_MASK(ADDR_ALIGN_MASK)
    ) u_dbus (
        .clk          (clk),
        .resetn       (resetn),
        .start        (bus_start),
        .is_write     (icode_q == ICODE_SW),
        .addr         (val3_q),
        .strobe       (req_q),
        .wdata        (valt_q),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .done         (bus_done),
        .rdata        (bus_rdata)
    );

    always_comb begin
        m_stall = is_mem_op(icode_q) && !bus_done;
        m_pc    = pc_q;
        m_icode = icode_q;
        m_dst   = dst_q;
        m_val   = (icode_q == ICODE_LW) ? bus_rdata : val3_q;
        m_wen   = (dst_q != 5'h0) && (icode_q != ICODE_SW) && !m_stall;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a latency-programmable bus responder
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] M_pc, M_val3, M_valt;
    logic [5:0]  M_icode;
    logic [4:0]  M_dst;
    logic [3:0]  M_req;
    logic        M_bubble;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic [31:0] m_pc;
    logic [5:0]  m_icode;
    logic [4:0]  m_dst;
    logic [31:0] m_val;
    logic        m_wen, m_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .resetn(resetn),
        .M_pc(M_pc), .M_val3(M_val3), .M_valt(M_valt), .M_icode(M_icode),
        .M_dst(M_dst), .M_req(M_req), .M_bubble(M_bubble),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .m_pc(m_pc), .m_icode(m_icode), .m_dst(m_dst),
        .m_val(m_val), .m_wen(m_wen), .m_stall(m_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] rand_icode();
        logic [5:0] kinds [6];
        kinds = '{ICODE_LW, ICODE_SW, ICODE_ADDIU, ICODE_SPE, ICODE_NOP, ICODE_LUI};
        return kinds[$urandom_range(0, 5)];
    endfunction

    task automatic drive_op(input logic [5:0] ic, input logic [31:0] pc, input logic [31:0] v3,
                            input logic [31:0] vt, input logic [4:0] dst, input logic bub);
        M_icode  = ic;
        M_pc     = pc;
        M_val3   = v3;
        M_valt   = vt;
        M_dst    = dst;
        M_bubble = bub;
        M_req    = (ic == ICODE_SW) ? 4'hF : ((ic == ICODE_LW) ? 4'($urandom) : 4'h0);
    endtask

    // a: REQ cycles before addr_ok; d: WAIT cycles until data_ok (0 = same cycle as addr_ok).
    // Model: a memory op stalls a+d+1 cycles; LW writes back the bus word, others write val3.
    task automatic run_op(input logic [5:0] ic, input logic [31:0] pc, input logic [31:0] v3,
                          input logic [31:0] vt, input logic [4:0] dst, input int a, input int d,
                          input logic [31:0] rd);
        int  stalls;
        int  phase;
        int  k;
        bit  mem;
        mem = (ic == ICODE_LW) || (ic == ICODE_SW);
        drive_op(ic, pc, v3, vt, dst, 1'b0);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        check("m_pc", m_pc, pc);
        check("m_icode", {26'h0, m_icode}, {26'h0, ic});
        check("m_dst", {27'h0, m_dst}, {27'h0, dst});
        stalls = 0;
        phase  = 0;
        k      = 0;
        while (m_stall && stalls < 64) begin
            stalls++;
            check("m_wen_stalled", {31'h0, m_wen}, 32'h0);
            if (phase == 0) begin
                check("dreq_valid", {31'h0, dreq_valid}, 32'h1);
                check("dreq_addr", dreq_addr, {v3[31:2], 2'b00});
                check("dreq_strobe", {28'h0, dreq_strobe}, (ic == ICODE_SW) ? 32'hF : 32'h0);
                check("dreq_data", dreq_data, vt);
            end else begin
                check("dreq_valid_wait", {31'h0, dreq_valid}, 32'h0);
                check("dreq_addr_wait", dreq_addr, 32'h0);
            end
            dresp_addr_ok = (phase == 0) && (k == a);
            dresp_data_ok = ((phase == 0) && (k == a) && (d == 0)) || ((phase == 1) && (k == d - 1));
            dresp_data    = dresp_data_ok ? rd : $urandom;
            drive_op(rand_icode(), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (phase == 0 && dresp_addr_ok) begin
                phase = 1;
                k     = 0;
            end else begin
                k++;
            end
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
        end
        check("stall_cycles", stalls, mem ? (a + d + 1) : 0);
        check("m_val", m_val, (ic == ICODE_LW) ? rd : v3);
        check("m_wen", {31'h0, m_wen}, {31'h0, (dst != 5'h0) && (ic != ICODE_SW)});
        check("dreq_valid_idle", {31'h0, dreq_valid}, 32'h0);
        // Stray responses across the advancing edge must not disturb anything.
        dresp_addr_ok = 1'($urandom);
        dresp_data_ok = 1'($urandom);
        dresp_data    = $urandom;
    endtask

    task automatic run_bubble();
        drive_op(rand_icode(), $urandom, $urandom, $urandom, 5'($urandom), 1'b1);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        check("bub_icode", {26'h0, m_icode}, 32'h0);
        check("bub_dst", {27'h0, m_dst}, 32'h0);
        check("bub_pc", m_pc, 32'h0);
        check("bub_wen", {31'h0, m_wen}, 32'h0);
        check("bub_val", m_val, 32'h0);
        check("bub_stall", {31'h0, m_stall}, 32'h0);
        check("bub_valid", {31'h0, dreq_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        drive_op(ICODE_NOP, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;
        #12;
        check("rst_valid", {31'h0, dreq_valid}, 32'h0);
        check("rst_stall", {31'h0, m_stall}, 32'h0);
        check("rst_wen", {31'h0, m_wen}, 32'h0);
        check("rst_val", m_val, 32'h0);
        check("rst_icode", {26'h0, m_icode}, 32'h0);
        check("rst_pc", m_pc, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(ICODE_ADDIU, 32'h0040_0000, 32'h10, 32'h0, 5'd5, 0, 0, 32'h0);
        run_op(ICODE_LW, 32'h0040_0004, 32'h8000_0004, 32'h0, 5'd7, 0, 0, 32'hDEAD_BEEF);
        run_op(ICODE_SW, 32'h0040_0008, 32'h8000_0013, 32'h1234_5678, 5'd0, 3, 2, 32'h0);
        run_op(ICODE_LW, 32'h0040_000C, 32'h8000_0020, 32'h0, 5'd3, 1, 1, 32'hCAFE_0001);
        run_op(ICODE_LW, 32'h0040_0010, 32'h8000_0026, 32'h0, 5'd4, 0, 2, 32'hCAFE_0002);
        run_op(ICODE_SW, 32'h0040_0014, 32'h8000_0031, 32'h0BAD_F00D, 5'd9, 0, 0, 32'h0);
        run_bubble();

        // Reset while waiting for the data phase; the late response must be ignored.
        drive_op(ICODE_LW, 32'h0040_0018, 32'h8000_0100, 32'h0, 5'd3, 1'b0);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        check("mid_req_valid", {31'h0, dreq_valid}, 32'h1);
        dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        check("mid_wait_valid", {31'h0, dreq_valid}, 32'h0);
        check("mid_wait_stall", {31'h0, m_stall}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", {31'h0, dreq_valid}, 32'h0);
        check("arst_stall", {31'h0, m_stall}, 32'h0);
        check("arst_wen", {31'h0, m_wen}, 32'h0);
        check("arst_val", m_val, 32'h0);
        M_bubble = 1'b1;
        @(posedge clk); #1;
        resetn        = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h5555_AAAA;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        check("late_wen", {31'h0, m_wen}, 32'h0);
        check("late_stall", {31'h0, m_stall}, 32'h0);
        check("late_valid", {31'h0, dreq_valid}, 32'h0);
        check("late_val", m_val, 32'h0);
        @(posedge clk); #1;
        check("late_idle_valid", {31'h0, dreq_valid}, 32'h0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                run_bubble();
            end else begin
                run_op(rand_icode(), $urandom, $urandom, $urandom,
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
